// File: rtl/if_ent_pkg.sv
// Shared types, widths and the reference result for the IfEnt datapath.
package if_ent_pkg;

  localparam int unsigned AW = 8;
  localparam int unsigned BW = 16;
  localparam int unsigned OW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  // Reference datapath result; A==B==0 is the divide-by-zero case, reported as 0 here.
  function automatic logic [OW-1:0] if_ent_ref(input logic [AW-1:0] a, input logic [BW-1:0] b);
    logic [AW-1:0] sq_lo;
    logic [AW-1:0] q;
    if ({8'b0, a} > b) begin
      return {8'b0, b[7:0]};
    end else if ({8'b0, a} < b) begin
      return {8'b0, a};
    end else if (a == '0) begin
      return '0;
    end else begin
      sq_lo = a * a;
      q     = sq_lo / a;
      return {8'b0, q + 8'd1};
    end
  endfunction

endpackage

// File: rtl/IfEnt.sv
// Combinational compare/ALU datapath shared by all requesters.
module IfEnt (
  input  logic [7:0]  A,
  input  logic [15:0] B,
  output logic [15:0] XOUT
);

  logic [7:0] sq_lo;
  logic [7:0] quo;

  // A>B passes B's low byte, A<B passes A, A==B computes ((A*A) mod 256)/A + 1.
  always_comb begin
    sq_lo = A * A;
    quo   = sq_lo / A;
    if ({8'b0, A} > B) begin
      XOUT = {8'b0, B[7:0]};
    end else if ({8'b0, A} < B) begin
      XOUT = {8'b0, A};
    end else begin
      XOUT = {8'b0, quo + 8'd1};
    end
  end

endmodule

// File: rtl/rr_pick.sv
// Round-robin pick: first valid requester after last_i, wrapping modulo NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  last_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  // Scan last+1, last+2, ... and keep the first hit.
  always_comb begin
    logic [IDW-1:0] cand;
    logic           found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = IDW'((32'(last_i) + off) % NREQ);
      if (!found && valid_i[cand]) begin
        found         = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/if_ent_sched.sv
// Round-robin sequencer sharing one IfEnt datapath among NREQ requesters.
module if_ent_sched
  import if_ent_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 1,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NREQ-1:0]    req_valid_i,
  input  logic [NREQ*AW-1:0] req_a_i,
  input  logic [NREQ*BW-1:0] req_b_i,
  output logic [NREQ-1:0]    req_ready_o,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [OW-1:0]    resp_data_o,
  output logic [IDW-1:0]   resp_id_o,
  output logic             resp_err_o,
  output logic [15:0]      done_cnt_o
);

  state_e          state_q;
  logic [IDW-1:0]  last_q;
  logic [IDW-1:0]  gid_q;
  logic [3:0]      cnt_q;
  logic [AW-1:0]   a_q;
  logic [BW-1:0]   b_q;
  logic            resp_valid_q;
  logic [OW-1:0]   resp_data_q;
  logic [IDW-1:0]  resp_id_q;
  logic            resp_err_q;
  logic [15:0]     done_cnt_q;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic [OW-1:0]   xout;
  logic            op_err;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .valid_i (req_valid_i),
    .last_i  (last_q),
    .grant_o (grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Only the captured operands ever reach the datapath.
  IfEnt u_if_ent (
    .A    (a_q),
    .B    (b_q),
    .XOUT (xout)
  );

  assign op_err = (a_q == '0) && (b_q == '0);

  // Sequencer FSM: grant and capture in idle, wait LAT cycles, hold the response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      last_q       <= IDW'(NREQ - 1);
      gid_q        <= '0;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      resp_err_q   <= 1'b0;
      done_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            a_q     <= req_a_i[AW*pick_idx +: AW];
            b_q     <= req_b_i[BW*pick_idx +: BW];
            gid_q   <= pick_idx;
            last_q  <= pick_idx;
            cnt_q   <= 4'(LAT - 1);
            state_q <= StExec;
          end
        end
        StExec: begin
          if (cnt_q == '0) begin
            // Divide-by-zero result is undefined on the datapath; report zero instead.
            resp_data_q  <= op_err ? '0 : xout;
            resp_id_q    <= gid_q;
            resp_err_q   <= op_err;
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            done_cnt_q   <= done_cnt_q + 16'd1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o  = (state_q == StIdle) ? grant : '0;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_id_o    = resp_id_q;
  assign resp_err_o   = resp_err_q;
  assign done_cnt_o   = done_cnt_q;

endmodule

// File: tb/tb_if_ent_sched.sv
// Self-checking bench for if_ent_sched: directed steps then randomized traffic.
module tb_if_ent_sched;

  localparam int NREQ = 4;
  localparam int LAT  = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*8-1:0]    req_a;
  logic [NREQ*16-1:0]   req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [15:0]          resp_data;
  logic [IDW-1:0]       resp_id;
  logic                 resp_err;
  logic [15:0]          done_cnt;

  int          n_chk = 0;
  int          n_err = 0;
  int          m_last;
  logic [15:0] m_done;
  time         last_hs;

  always #5 clk = ~clk;

  if_ent_sched #(
    .NREQ (NREQ),
    .LAT  (LAT),
    .IDW  (IDW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_ready_o  (req_ready),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .resp_id_o    (resp_id),
    .resp_err_o   (resp_err),
    .done_cnt_o   (done_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Datapath rule in plain integer arithmetic.
  function automatic int ref_x(input int a, input int b);
    if (a > b) return b % 256;
    if (a < b) return a;
    return ((a * a) % 256) / a + 1;
  endfunction

  // Serve one transaction from the current request inputs; called just after a clock edge.
  task automatic serve(input int hold, input bit chk_sp);
    int          id;
    int          a;
    int          b;
    logic        err;
    logic [15:0] exp_d;
    id = -1;
    for (int off = 1; off <= NREQ; off++) begin
      int c;
      c = (m_last + off) % NREQ;
      if (id < 0 && req_valid[c]) id = c;
    end
    if (id < 0) begin
      check("no_request", 32'(req_valid), 32'hffff_ffff);
      return;
    end
    a     = int'(req_a[8*id +: 8]);
    b     = int'(req_b[16*id +: 16]);
    err   = (a == 0) && (b == 0);
    exp_d = err ? 16'h0 : 16'(ref_x(a, b));
    #1;
    check("grant", 32'(req_ready), 32'(1 << id));
    @(posedge clk);
    if (chk_sp) check("spacing", 32'($time - last_hs), 32'((LAT + 2) * 10));
    last_hs = $time;
    m_last  = id;
    #1;
    // Operands after the handshake must be ignored.
    req_a[8*id +: 8]   = 8'($urandom);
    req_b[16*id +: 16] = 16'($urandom);
    if (hold == 0) resp_ready = 1'b1;
    #1;
    check("ready_low_exec", 32'(req_ready), 32'h0);
    for (int i = 1; i < LAT; i++) begin
      @(posedge clk);
      #2;
      check("early_valid", 32'(resp_valid), 32'h0);
    end
    @(posedge clk);
    #2;
    check("resp_valid", 32'(resp_valid), 32'h1);
    check("resp_data", 32'(resp_data), 32'(exp_d));
    check("resp_id", 32'(resp_id), 32'(id));
    check("resp_err", 32'(resp_err), 32'(err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #2;
      check("hold_valid", 32'(resp_valid), 32'h1);
      check("hold_data", 32'(resp_data), 32'(exp_d));
      check("hold_id", 32'(resp_id), 32'(id));
      check("hold_ready", 32'(req_ready), 32'h0);
      check("hold_cnt", 32'(done_cnt), 32'(m_done));
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    m_done++;
    check("resp_drop", 32'(resp_valid), 32'h0);
    check("done_cnt", 32'(done_cnt), 32'(m_done));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    last_hs    = 0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    m_last = NREQ - 1;
    m_done = '0;
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_valid", 32'(resp_valid), 32'h0);
    check("rst_data", 32'(resp_data), 32'h0);
    check("rst_id", 32'(resp_id), 32'h0);
    check("rst_err", 32'(resp_err), 32'h0);
    check("rst_cnt", 32'(done_cnt), 32'h0);

    // Directed operand cases.
    req_valid = 4'b0100; req_a[23:16] = 8'd200; req_b[47:32] = 16'd100;
    serve(0, 1'b0);
    req_valid = 4'b0010; req_a[15:8] = 8'd5; req_b[31:16] = 16'h1234;
    serve(0, 1'b0);
    req_valid = 4'b0001; req_a[7:0] = 8'd3; req_b[15:0] = 16'd3;
    serve(0, 1'b0);
    req_a[7:0] = 8'd16; req_b[15:0] = 16'd16;
    serve(0, 1'b0);
    req_a[7:0] = 8'd0; req_b[15:0] = 16'd0;
    serve(0, 1'b0);

    // All requesters busy: rotation and back-to-back spacing.
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      req_a[8*i +: 8]   = 8'($urandom);
      req_b[16*i +: 16] = 16'($urandom_range(0, 300));
    end
    for (int t = 0; t < 8; t++) serve(0, t != 0);

    // Consumer stalls for ten cycles.
    req_valid = 4'b0010; req_a[15:8] = 8'd40; req_b[31:16] = 16'd40;
    serve(10, 1'b0);

    // Reset in the middle of a transaction.
    req_valid = 4'b1000; req_a[31:24] = 8'd7; req_b[63:48] = 16'd9;
    #1;
    check("pre_rst_grant", 32'(req_ready), 32'h8);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    m_last = NREQ - 1;
    m_done = '0;
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    check("mid_rst_valid", 32'(resp_valid), 32'h0);
    check("mid_rst_data", 32'(resp_data), 32'h0);
    check("mid_rst_id", 32'(resp_id), 32'h0);
    check("mid_rst_err", 32'(resp_err), 32'h0);
    check("mid_rst_cnt", 32'(done_cnt), 32'h0);
    repeat (LAT + 2) begin
      @(posedge clk);
      #1;
      check("abandoned", 32'(resp_valid), 32'h0);
    end
    req_valid = 4'b1111;
    serve(0, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      req_valid = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        int a;
        int mode;
        a    = $urandom_range(0, 255);
        mode = $urandom_range(0, 3);
        req_a[8*i +: 8] = 8'(a);
        case (mode)
          0:       req_b[16*i +: 16] = 16'(a);
          1:       req_b[16*i +: 16] = 16'($urandom_range(0, 255));
          2:       req_b[16*i +: 16] = 16'($urandom);
          default: begin
            req_a[8*i +: 8]   = 8'h0;
            req_b[16*i +: 16] = 16'h0;
          end
        endcase
      end
      serve($urandom_range(0, 2), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
